// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan controller
//
// Contents:
//   NDIGITS    number of multiplexed digits
//   NIB_W      width of one displayed nibble
//   AN_OFF     anode pattern with every digit dark (active-low anodes)
//   slot_e     phase of the current digit slot (dead time vs. lit)
//   an_onehot  active-low one-hot anode pattern for a digit index
package seg7_pkg;

    localparam int          NDIGITS = 4;
    localparam int          NIB_W   = 4;
    localparam logic [3:0]  AN_OFF  = 4'b1111;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_e;

    function automatic logic [3:0] an_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/LEDdecoder.sv
// rtl/LEDdecoder.sv - hex nibble to seven-segment pattern decoder
//
// Ports:
//   nibble  in   4  hex value 0..F
//   seg     out  7  segment pattern {g,f,e,d,c,b,a}, active-low (0 lights a segment)
module LEDdecoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - time-multiplexed 4-digit common-anode display driver
//
// Parameters:
//   PRESCALE  clock cycles per digit slot (>= 2)
//   BLANK     dead-time cycles at the start of each slot (1 <= BLANK < PRESCALE)
//
// Ports:
//   clk         in   1   system clock
//   resetn      in   1   asynchronous active-low reset
//   data_in     in   16  word to display, digit 0 = data_in[3:0] (rightmost)
//   load        in   1   strobe: capture data_in into the shadow register
//   blank_all   in   1   force all anodes off; counters keep running
//   pending     out  1   a loaded word is waiting for the next frame boundary
//   an          out  4   anode enables, active-low, one-hot-low or all ones
//   seg         out  7   decoder output for the current nibble
//   digit_sel   out  2   index of the current slot
//   frame_tick  out  1   one-cycle pulse in the first cycle of digit 0
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        blank_all,
    output logic        pending,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int                CNT_W   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  BLANK_C = CNT_W'(BLANK);

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        digit_sel_next;
    logic [15:0]       shadow, shadow_next;
    logic [15:0]       disp, disp_next;
    logic              pending_next;
    logic [NIB_W-1:0]  nibble, nibble_next;
    logic [3:0]        an_next;
    logic              frame_tick_next;
    logic              boundary;
    slot_e             slot_next;

    // Outputs are registered from next-state values so that an, nibble and
    // frame_tick line up with the cnt/digit_sel they describe in the same cycle.
    always_comb begin
        cnt_next        = cnt + 1'b1;
        digit_sel_next  = digit_sel;
        boundary        = 1'b0;
        shadow_next     = shadow;
        disp_next       = disp;
        pending_next    = pending;
        an_next         = AN_OFF;
        nibble_next     = '0;
        frame_tick_next = 1'b0;

        if (cnt == CNT_MAX) begin
            cnt_next       = '0;
            digit_sel_next = digit_sel + 2'd1;
            boundary       = (digit_sel == 2'(NDIGITS - 1));
        end

        if (load) begin
            shadow_next  = data_in;
            pending_next = 1'b1;
        end

        // Commit only at the frame boundary; a load on that very cycle goes
        // straight to the display so it is not held back a whole frame.
        if (boundary) begin
            if (load) begin
                disp_next = data_in;
            end else if (pending) begin
                disp_next = shadow;
            end
            pending_next = 1'b0;
        end

        slot_next = (cnt_next < BLANK_C) ? SLOT_BLANK : SLOT_SHOW;
        if (!blank_all && slot_next == SLOT_SHOW) begin
            an_next = an_onehot(digit_sel_next);
        end

        // Nibble follows the slot from its first cycle, so it has settled
        // through the decoder before the anode turns on.
        case (digit_sel_next)
            2'd0:    nibble_next = disp_next[3:0];
            2'd1:    nibble_next = disp_next[7:4];
            2'd2:    nibble_next = disp_next[11:8];
            default: nibble_next = disp_next[15:12];
        endcase

        frame_tick_next = boundary;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            digit_sel  <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            nibble     <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            digit_sel  <= digit_sel_next;
            shadow     <= shadow_next;
            disp       <= disp_next;
            pending    <= pending_next;
            an         <= an_next;
            nibble     <= nibble_next;
            frame_tick <= frame_tick_next;
        end
    end

    LEDdecoder u_decoder (
        .nibble (nibble),
        .seg    (seg)
    );

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb/tb_seg7_scan_controller.sv - scoreboard bench for seg7_scan_controller
module tb_seg7_scan_controller;

    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] data_in;
    logic        load;
    logic        blank_all;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    seg7_scan_controller #(.PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .load       (load),
        .blank_all  (blank_all),
        .pending    (pending),
        .an         (an),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] dsel;
        logic       pending;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];

    // Standard hex glyphs, active-high {g..a}; the display is common-anode so
    // the lit segments are driven low.
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] hi;
        case (v)
            0: hi = 7'h3F;  1: hi = 7'h06;  2: hi = 7'h5B;  3: hi = 7'h4F;
            4: hi = 7'h66;  5: hi = 7'h6D;  6: hi = 7'h7D;  7: hi = 7'h07;
            8: hi = 7'h7F;  9: hi = 7'h6F;  10: hi = 7'h77; 11: hi = 7'h7C;
            12: hi = 7'h39; 13: hi = 7'h5E; 14: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t counts cycles since reset; slot and digit follow
    // from plain division. Loads since the last frame boundary are remembered
    // as "the newest word", which replaces the display at the next boundary.
    int          mt;
    logic [15:0] m_disp;
    logic [15:0] m_last;
    logic        m_has;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mt     = 0;
            m_disp = '0;
            m_last = '0;
            m_has  = 1'b0;
            exp_q.delete();
        end else begin
            exp_t e;
            int   c, d;
            logic bnd;
            logic [3:0] bit1;
            bnd = ((mt % FRAME) == FRAME - 1);
            if (load) begin
                m_last = data_in;
                m_has  = 1'b1;
            end
            if (bnd) begin
                if (m_has) m_disp = m_last;
                m_has = 1'b0;
            end
            mt = mt + 1;
            c  = mt % P;
            d  = (mt / P) % 4;
            bit1 = 4'b0001 << d;
            e.an      = (blank_all || c < B) ? 4'b1111 : ~bit1;
            e.seg     = glyph(int'((m_disp >> (4 * d)) & 16'h000F));
            e.dsel    = 2'(d);
            e.pending = m_has;
            e.ft      = bnd;
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            check("reset_an", 16'(an), 16'hF);
            check("reset_dsel", 16'(digit_sel), 16'h0);
            check("reset_pending", 16'(pending), 16'h0);
            check("reset_ft", 16'(frame_tick), 16'h0);
            check("reset_seg", 16'(seg), 16'(glyph(0)));
        end else if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("an", 16'(an), 16'(e.an));
            check("seg", 16'(seg), 16'(e.seg));
            check("digit_sel", 16'(digit_sel), 16'(e.dsel));
            check("pending", 16'(pending), 16'(e.pending));
            check("frame_tick", 16'(frame_tick), 16'(e.ft));
            check("an_onehot", 16'($countones(~an) <= 1), 16'h1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Returns at posedge+2 with the model sitting at the requested frame phase.
    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while ((mt % FRAME) != ph) begin
            step();
            n++;
            if (n > 4 * FRAME) begin
                checks++;
                errors++;
                $display("FAIL wait_phase: phase %0d not reached, got %0d", ph, mt % FRAME);
                return;
            end
        end
    endtask

    task automatic pulse_load(input logic [15:0] w);
        data_in = w;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        data_in   = '0;
        load      = 1'b0;
        blank_all = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;

        // Idle scan with an all-zero display.
        repeat (2 * FRAME) step();

        // Load during digit 1, commit at the next wrap.
        wait_phase(P);
        pulse_load(16'h1A3F);
        repeat (2 * FRAME) step();

        // Load exactly on the boundary cycle: bypass, pending never set.
        wait_phase(FRAME - 1);
        pulse_load(16'hBEEF);
        repeat (FRAME) step();

        // Two loads in one frame: only the second is ever shown.
        wait_phase(3);
        pulse_load(16'h1111);
        wait_phase(20);
        pulse_load(16'h2222);
        repeat (2 * FRAME) step();

        // Blank the display for 20 cycles mid-frame.
        wait_phase(10);
        blank_all = 1'b1;
        repeat (20) step();
        blank_all = 1'b0;
        repeat (FRAME) step();

        // Random loads and blanking.
        for (int i = 0; i < 1500; i++) begin
            data_in   = 16'($urandom);
            load      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) blank_all = ~blank_all;
            step();
        end
        load      = 1'b0;
        blank_all = 1'b0;
        repeat (FRAME) step();

        // Reset during SHOW of digit 2 with a word pending.
        wait_phase(2 * P + 1);
        pulse_load(16'h5A5A);
        wait_phase(2 * P + 5);
        check("pre_reset_an", 16'(an), 16'hB);
        resetn = 1'b0;
        #1;
        check("async_an", 16'(an), 16'hF);
        check("async_pending", 16'(pending), 16'h0);
        check("async_dsel", 16'(digit_sel), 16'h0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        repeat (2 * FRAME) step();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes a 4-digit common-anode seven-segment display.
- Holds a 16-bit display word and steps through the digits one at a time: per digit, a blanking interval, then the digit's anode is enabled with its nibble routed through the existing LEDdecoder.
- New words are double-buffered and committed only at frame boundaries, so the display never shows half-old/half-new data.
- Sits between the user logic (for example a counter or register readout) and the board's anode and segment pins.

Parameters:
- PRESCALE, 8, clock cycles per digit slot; at least 2.
- BLANK, 2, dead-time cycles at the start of each slot with all anodes off; 1 <= BLANK < PRESCALE.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- data_in  in  16  word to display; digit 0 = data_in[3:0] (rightmost) ... digit 3 = data_in[15:12]
- load  in  1  single-cycle strobe; captures data_in into the shadow register
- blank_all  in  1  while 1, forces all anodes off; counters keep running
- pending  out  1  1 while a loaded word waits for commit
- an  out  4  anode enables, active-low, one-hot-low or all-ones
- seg  out  7  LEDdecoder output for the current nibble, polarity unchanged
- digit_sel  out  2  index of the current slot
- frame_tick  out  1  one-cycle pulse at commit/frame boundary

Behaviour:
- Reset (async assert, sync release) values:
  - cnt = 0, digit_sel = 0
  - shadow = 0, disp = 0, pending = 0
  - an = 4'b1111, nibble = 0, frame_tick = 0
  - seg = decoder(0)
- Slot counter cnt runs 0..PRESCALE-1 and increments every cycle.
- At cnt == PRESCALE-1:
  - cnt <= 0, digit_sel <= digit_sel + 1, wrapping 3 -> 0.
  - On the 3 -> 0 wrap this is the frame boundary.
- Per-slot states, decoded from cnt:
  - BLANK: cnt < BLANK.
  - SHOW: cnt >= BLANK.
- an, nibble and frame_tick are registered and reflect the state of the current cnt/digit_sel in the same cycle; they are computed from next-state values.
- an in BLANK, or whenever blank_all = 1: 4'b1111.
- an in SHOW: bit digit_sel low, all others high.
- nibble: disp[4*digit_sel +: 4]. It is updated at slot start, so it is already stable during BLANK.
- seg: combinational LEDdecoder(nibble), giving one decoder delay after the register.
- Load and commit rules:
  - load = 1: shadow <= data_in, pending <= 1.
  - Frame boundary (the cycle where digit_sel goes 3 -> 0) with pending = 1: disp <= shadow, pending <= 0.
  - Frame boundary with pending = 0: disp unchanged.
  - frame_tick = 1 in the first cycle of digit 0.
- Boundary conditions:
  - load in the same cycle as the boundary: disp <= data_in directly (bypass), shadow <= data_in, pending <= 0.
  - Multiple loads within one frame: the last one wins; earlier words are never displayed.
  - blank_all has no effect on cnt, digit_sel, disp or commits.
  - Reset mid-slot: immediate return to reset values; an = 1111 asynchronously.
- Invariant: at most one an bit is low in any cycle. an is never low during the BLANK cycles, so there is no ghosting.
- Full frame: 4*PRESCALE cycles.

Decomposition:
- Shared package (seg7_pkg):
  - NDIGITS = 4
  - AN_OFF = 4'b1111
  - Nibble width constant = 4
- Sub-module: the existing LEDdecoder, instantiated once on the registered nibble. No other sub-modules.
- The slot-counter and commit logic stay in this module.

Test Plan:
- Reset and idle: resetn low with PRESCALE=8, BLANK=2 -> an=1111, digit_sel=0, pending=0, seg=decoder(0); after release, an cycles 1111,1111,1110x6, then 1111,1111,1101x6 ... with a period of 32 cycles.
- Load and commit: load data_in=16'h1A3F at digit 1 -> pending=1 until the 3->0 wrap; at frame_tick pending=0 and disp=16'h1A3F; next frame seg shows F,3,A,1 on an=1110,1101,1011,0111.
- Bypass: load 16'hBEEF exactly on the boundary cycle -> pending never asserts; the same frame's digit 0 shows F.
- Last load wins: loads 16'h1111 then 16'h2222 within one frame -> after commit all digits show 2; 1 is never driven.
- blank_all: assert for 20 cycles mid-frame -> an=1111 throughout; digit_sel and frame_tick timing identical to an unblanked run.
- Async reset mid-SHOW: drop resetn at cnt=5, digit 2 -> an=1111 in the same cycle without waiting for clk; disp=0 and pending=0 after release.
